jump_ctrl: RTL and testbench

Button-to-jump controller sitting between the player push-button and the game FSM. Synchronises and debounces the raw button, measures hold time in prescaled ticks, and presents the result as a 16-bit `press_time` with a valid/ack handshake. It locks out new presses while the game animates a jump/shift and sequences the game-over/restart request.

---
 rtl/jump_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_jump_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_ctrl.sv
// Push-button to jump controller: synchronise and debounce the button, charge
// while it is held, hand the charge to the game FSM, and sequence restart.
module jump_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 1000,
    parameter int MAX_PRESS       = 200,
    parameter int MIN_PRESS       = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_i,
    input  logic        game_busy_i,
    input  logic        game_over_i,
    input  logic        press_ack_i,
    output logic        press_valid_o,
    output logic [15:0] press_time_o,
    output logic        charging_o,
    output logic [7:0]  charge_level_o,
    output logic        restart_req_o
);

    // state      | meaning
    // IDLE       | waiting for a fresh debounced press, charge held at 0
    // CHARGE     | button held, charge grows one step per TICK_DIV cycles
    // ISSUE      | press_time presented with press_valid until acked
    // WAIT_BUSY  | acked, waiting for the game to start animating
    // WAIT_DONE  | game animating, new presses locked out
    // GAMEOVER   | waiting for a full press/release to request a restart

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = ($clog2(TICK_DIV) > 10) ? $clog2(TICK_DIV) : 10;
    localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]    CHARGE_MAX = 8'(MAX_PRESS);
    localparam logic [7:0]    CHARGE_MIN = 8'(MIN_PRESS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHARGE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAMEOVER
    } state_t;

    logic [1:0]    sync_q;
    logic [1:0]    sync_vld_q;
    logic          btn_s;
    logic          btn_db_q;
    logic          btn_dq;
    logic [DW-1:0] dcnt_q;
    logic          arm_q;
    logic          rise;
    logic          fall;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    charge_q, charge_d;
    logic [7:0]    charge_inc;
    logic          seen_rise_q, seen_rise_d;
    logic          restart_q, restart_d;

    assign btn_s = sync_q[1];
    assign rise  = btn_db_q & ~btn_dq;
    assign fall  = ~btn_db_q & btn_dq;

    // arm_q blocks a button held through reset from being taken as a press:
    // a debounced low level must be seen once before any rise is honoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            sync_vld_q <= '0;
            btn_db_q   <= 1'b0;
            btn_dq     <= 1'b0;
            dcnt_q     <= '0;
            arm_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], btn_i};
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            btn_dq     <= btn_db_q;
            if (btn_s == btn_db_q) begin
                dcnt_q <= '0;
            end else if (dcnt_q == DCNT_LAST) begin
                btn_db_q <= ~btn_db_q;
                dcnt_q   <= '0;
            end else begin
                dcnt_q <= dcnt_q + 1'b1;
            end
            if (sync_vld_q[1] && !btn_s && !btn_db_q) begin
                arm_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            charge_q    <= '0;
            seen_rise_q <= 1'b0;
            restart_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            charge_q    <= charge_d;
            seen_rise_q <= seen_rise_d;
            restart_q   <= restart_d;
        end
    end

    assign charge_inc = (charge_q < CHARGE_MAX) ? charge_q + 8'd1 : charge_q;

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        charge_d    = charge_q;
        seen_rise_d = seen_rise_q;
        restart_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise && arm_q && !game_busy_i) begin
                    state_d  = ST_CHARGE;
                    presc_d  = '0;
                    charge_d = '0;
                end
            end
            ST_CHARGE: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d  = '0;
                    charge_d = charge_inc;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                // the tick landing on the release edge still counts
                if (fall) begin
                    state_d = (charge_d >= CHARGE_MIN) ? ST_ISSUE : ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (press_ack_i) begin
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (game_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!game_busy_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAMEOVER: begin
                if (rise) begin
                    seen_rise_d = 1'b1;
                end
                if (fall && seen_rise_q) begin
                    restart_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (game_over_i && state_q != ST_GAMEOVER) begin
            state_d   = ST_GAMEOVER;
            restart_d = 1'b0;
        end
        if (state_d == ST_IDLE || state_d == ST_GAMEOVER) begin
            charge_d = '0;
        end
        if (state_d != ST_GAMEOVER) begin
            seen_rise_d = 1'b0;
        end
    end

    assign press_valid_o  = (state_q == ST_ISSUE);
    assign press_time_o   = press_valid_o ? {8'd0, charge_q} : 16'd0;
    assign charging_o     = (state_q == ST_CHARGE);
    assign charge_level_o = charge_q;
    assign restart_req_o  = restart_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed plus randomized bench for jump_ctrl; expected charges come from
// hold time arithmetic, timing from the documented input-path latency.
module tb_jump_ctrl;

    localparam int DEB  = 4;
    localparam int TICK = 10;
    localparam int MAXP = 20;
    localparam int MINP = 2;

    logic        clk;
    logic        rst_n;
    logic        btn_i;
    logic        game_busy_i;
    logic        game_over_i;
    logic        press_ack_i;
    logic        press_valid_o;
    logic [15:0] press_time_o;
    logic        charging_o;
    logic [7:0]  charge_level_o;
    logic        restart_req_o;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    jump_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_DIV       (TICK),
        .MAX_PRESS      (MAXP),
        .MIN_PRESS      (MINP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_i         (btn_i),
        .game_busy_i   (game_busy_i),
        .game_over_i   (game_over_i),
        .press_ack_i   (press_ack_i),
        .press_valid_o (press_valid_o),
        .press_time_o  (press_time_o),
        .charging_o    (charging_o),
        .charge_level_o(charge_level_o),
        .restart_req_o (restart_req_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_charge(input int n);
        int c;
        c = n / TICK;
        return (c > MAXP) ? MAXP : c;
    endfunction

    // Holds the raw button for n cycles, then counts charging cycles until it drops.
    task automatic press_measure(input int n, output int chg);
        chg = 0;
        btn_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (charging_o) chg++;
        end
        btn_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (charging_o) chg++;
            else if (chg > 0) break;
        end
    endtask

    task automatic issue_flow(input int expv, input int ack_dly, input bit busy_w_ack,
                              input int busy_len);
        chk("valid_after_fall", press_valid_o, 1);
        chk("press_time", press_time_o, expv);
        for (int k = 0; k < ack_dly; k++) begin
            @(negedge clk);
            chk("valid_hold", press_valid_o, 1);
            chk("time_hold", press_time_o, expv);
        end
        press_ack_i = 1'b1;
        if (busy_w_ack) game_busy_i = 1'b1;
        @(negedge clk);
        press_ack_i = 1'b0;
        chk("valid_drop_after_ack", press_valid_o, 0);
        chk("level_held_after_ack", charge_level_o, expv);
        if (!busy_w_ack) begin
            repeat (3) @(negedge clk);
            chk("level_held_wait_busy", charge_level_o, expv);
            game_busy_i = 1'b1;
        end
        repeat (busy_len) @(negedge clk);
        chk("level_held_busy", charge_level_o, expv);
        chk("no_valid_busy", press_valid_o, 0);
        game_busy_i = 1'b0;
        @(negedge clk);
        chk("idle_after_busy", charge_level_o, 0);
    endtask

    task automatic gameover_press(input int n, output int pulses, output int first_idx,
                                  output int chg);
        pulses = 0;
        first_idx = -1;
        chg = 0;
        btn_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (restart_req_o) pulses++;
            if (charging_o) chg++;
        end
        btn_i = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (charging_o) chg++;
            if (restart_req_o) begin
                pulses++;
                if (first_idx < 0) first_idx = i;
            end
        end
    endtask

    initial begin
        int chg, n, expv, pulses, first_idx, found;

        rst_n = 1'b1;
        btn_i = 1'b1;
        game_busy_i = 1'b0;
        game_over_i = 1'b0;
        press_ack_i = 1'b0;

        // reset with the button already held
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", press_valid_o, 0);
        chk("rst_time", press_time_o, 0);
        chk("rst_charging", charging_o, 0);
        chk("rst_level", charge_level_o, 0);
        chk("rst_restart", restart_req_o, 0);
        rst_n = 1'b1;
        chg = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (charging_o) chg++;
        end
        chk("held_through_reset_no_charge", chg, 0);
        btn_i = 1'b0;
        repeat (20) @(negedge clk);

        // normal press, ack after 7 cycles, busy for 30 cycles
        press_measure(100, chg);
        chk("normal_charging_cycles", chg, 100);
        issue_flow(model_charge(100), 7, 1'b0, 30);

        // saturation
        press_measure(500, chg);
        chk("sat_charging_cycles", chg, 500);
        issue_flow(model_charge(500), 0, 1'b1, 5);

        // tap below the minimum
        press_measure(15, chg);
        chk("tap_charging_cycles", chg, 15);
        chk("tap_no_valid", press_valid_o, 0);
        chk("tap_level_idle", charge_level_o, 0);
        repeat (5) @(negedge clk);

        // short glitches never reach the debounced level
        chg = 0;
        for (int g = 0; g < 4; g++) begin
            btn_i = 1'b1;
            repeat (DEB - 1) begin
                @(negedge clk);
                if (charging_o) chg++;
            end
            btn_i = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (charging_o) chg++;
            end
        end
        chk("glitch_no_charge", chg, 0);

        // press during busy stays ignored after busy falls
        chg = 0;
        game_busy_i = 1'b1;
        btn_i = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (charging_o) chg++;
        end
        game_busy_i = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (charging_o) chg++;
        end
        btn_i = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (charging_o) chg++;
        end
        chk("busy_lockout_no_charge", chg, 0);
        chk("busy_lockout_no_valid", press_valid_o, 0);

        // randomized presses against the hold-time model
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(12, 260);
            expv = model_charge(n);
            press_measure(n, chg);
            chk("rand_charging_cycles", chg, n);
            if (expv >= MINP) begin
                issue_flow(expv, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                           $urandom_range(1, 20));
            end else begin
                chk("rand_tap_no_valid", press_valid_o, 0);
                chk("rand_tap_level", charge_level_o, 0);
            end
            repeat ($urandom_range(1, 10)) @(negedge clk);
        end

        // game over mid-charge at charge 5
        found = 0;
        btn_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (charge_level_o == 8'd5) begin
                found = 1;
                break;
            end
        end
        chk("reached_charge5", found, 1);
        game_over_i = 1'b1;
        @(negedge clk);
        chk("go_charging_off", charging_o, 0);
        chk("go_level_zero", charge_level_o, 0);
        chk("go_no_valid", press_valid_o, 0);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (restart_req_o || press_valid_o) pulses++;
        end
        btn_i = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (restart_req_o || press_valid_o) pulses++;
        end
        chk("go_release_without_rise_quiet", pulses, 0);
        game_over_i = 1'b0;
        gameover_press(50, pulses, first_idx, chg);
        chk("restart_pulse_count", pulses, 1);
        chk("restart_pulse_timing", first_idx, DEB + 3);
        chk("gameover_no_charge", chg, 0);
        press_measure(30, chg);
        chk("post_restart_charging", chg, 30);
        issue_flow(model_charge(30), 2, 1'b0, 4);

        // game over and ack in the same cycle
        press_measure(40, chg);
        chk("goack_charging", chg, 40);
        chk("goack_valid", press_valid_o, 1);
        press_ack_i = 1'b1;
        game_over_i = 1'b1;
        @(negedge clk);
        press_ack_i = 1'b0;
        chk("goack_valid_drop", press_valid_o, 0);
        chk("goack_level_zero", charge_level_o, 0);
        game_over_i = 1'b0;
        repeat (3) @(negedge clk);
        gameover_press(20, pulses, first_idx, chg);
        chk("goack_restart_count", pulses, 1);
        chk("goack_no_charge", chg, 0);

        // asynchronous reset while a press is pending
        press_measure(40, chg);
        chk("rstissue_valid", press_valid_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstissue_valid_async", press_valid_o, 0);
        chk("rstissue_time_async", press_time_o, 0);
        chk("rstissue_level_async", charge_level_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rstissue_idle_charging", charging_o, 0);
        chk("rstissue_idle_valid", press_valid_o, 0);
        press_measure(30, chg);
        chk("rstissue_post_charging", chg, 30);
        issue_flow(model_charge(30), 1, 1'b1, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
